cdc_sender_fsm: RTL and testbench

//   Source-domain half of the four-phase req/ack CDC link. Accepts words from a

---
 rtl/cdc_sender_if.sv | 25 ++
 rtl/cdc_sender_fsm.sv | 86 ++++++++
 tb/tb_cdc_sender_fsm.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cdc_sender_if.sv
// Producer and receiver-link signals of the source half of the four-phase req/ack CDC link.
// The slave modport is the sender FSM. The master modport is the environment: the producer plus the receiver's raw ack.
interface cdc_sender_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic                  src_valid;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_ready;
    logic                  ack_in;
    logic                  req_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  xfer_count;

    modport slave (
        input  src_valid, src_data, ack_in,
        output src_ready, req_out, data_out, busy, xfer_count
    );

    modport master (
        output src_valid, src_data, ack_in,
        input  src_ready, req_out, data_out, busy, xfer_count
    );
endinterface

// File: rtl/cdc_sender_fsm.sv
// Source-domain sender of the four-phase req/ack CDC link.
// It holds each accepted word on data_out and drives a registered req_out until the receiver's synchronized ack completes the handshake.
module cdc_sender_fsm #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    cdc_sender_if.slave bus
);
    // state  | meaning
    // S_IDLE | ready for a word; accept captures src_data into data_out
    // S_LOAD | data_out settles one cycle before req_out rises
    // S_REQ  | req_out high, waiting for ack_sync to rise
    // S_REL  | req_out low, waiting for ack_sync to fall; counts the transfer
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_REQ, S_REL} state_t;

    state_t                 state_q, state_d;
    logic                   req_q, req_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic                   ack_sync;

    assign ack_sync = ack_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], bus.ack_in};
        case (state_q)
            S_IDLE: begin
                if (bus.src_valid) begin
                    data_d  = bus.src_data;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_REQ;
                req_d   = 1'b1;
            end
            S_REQ: begin
                if (ack_sync) begin
                    state_d = S_REL;
                    req_d   = 1'b0;
                end
            end
            S_REL: begin
                if (!ack_sync) begin
                    state_d = S_IDLE;
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            data_q     <= '0;
            cnt_q      <= '0;
            ack_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            ack_sync_q <= ack_sync_d;
        end
    end

    // ready decodes the state register only, so there is no path from src_valid to src_ready
    assign bus.src_ready  = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.req_out    = req_q;
    assign bus.data_out   = data_q;
    assign bus.xfer_count = cnt_q;
endmodule

// File: tb/tb_cdc_sender_fsm.sv
// Directed bench for cdc_sender_fsm with a delayed-ack receiver model.
// CNT_WIDTH is 4 so that the counter wrap is reachable.
module tb_cdc_sender_fsm;
    localparam int DW = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    cdc_sender_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bif ();

    cdc_sender_fsm #(.DATA_WIDTH(DW), .SYNC_STAGES(2), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bif)
    );

    // Receiver model: ack follows req_out three cycles later unless stalled or forced.
    logic [2:0] ack_dly;
    logic       ack_en, ack_force_en, ack_force;
    always @(posedge clk or negedge rst_b)
        if (!rst_b) ack_dly <= '0;
        else        ack_dly <= {ack_dly[1:0], bif.req_out};
    assign bif.ack_in = ack_force_en ? ack_force : (ack_en & ack_dly[2]);

    int accepts = 0;
    always @(posedge clk)
        if (rst_b && bif.src_valid && bif.src_ready) accepts <= accepts + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [DW-1:0] word;
        logic          keep;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    vec_t vt[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bif.src_ready && n < 300) begin tick(); n++; end
        if (n >= 300) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_xfer(input logic [DW-1:0] word, input logic keep, input logic [CW-1:0] exp_cnt,
                            output int req_hi, output int busy_cyc);
        int n, bad;
        wait_ready();
        bif.src_valid = 1'b1;
        bif.src_data  = word;
        tick();
        check("accept_data", 32'(bif.data_out), 32'(word));
        check("load_req_low", 32'(bif.req_out), 32'd0);
        check("load_busy", 32'(bif.busy), 32'd1);
        if (!keep) bif.src_valid = 1'b0;
        bif.src_data = ~word;
        tick();
        check("req_rise", 32'(bif.req_out), 32'd1);
        n = 0; bad = 0; req_hi = 0;
        while (bif.busy && n < 300) begin
            if (bif.data_out !== word) bad++;
            if (bif.req_out) req_hi++;
            tick();
            n++;
        end
        busy_cyc = n + 1;
        check("xfer_timeout", 32'(n < 300), 32'd1);
        check("data_stable", 32'(bad), 32'd0);
        check("xfer_count", 32'(bif.xfer_count), 32'(exp_cnt));
        check("ready_back", 32'(bif.src_ready), 32'd1);
    endtask

    initial begin
        int rh, bc, a0, bad;

        vt[0] = '{8'h01, 1'b1, 4'd2};
        vt[1] = '{8'h02, 1'b1, 4'd3};
        vt[2] = '{8'h03, 1'b1, 4'd4};
        vt[3] = '{8'h04, 1'b0, 4'd5};

        rst_b = 1'b0;
        bif.src_valid = 1'b0;
        bif.src_data  = '0;
        ack_en = 1'b1; ack_force_en = 1'b0; ack_force = 1'b0;

        // Reset, then ten idle cycles
        repeat (3) tick();
        @(negedge clk); rst_b = 1'b1;
        repeat (10) tick();
        check("rst_ready", 32'(bif.src_ready), 32'd1);
        check("rst_req", 32'(bif.req_out), 32'd0);
        check("rst_data", 32'(bif.data_out), 32'd0);
        check("rst_count", 32'(bif.xfer_count), 32'd0);
        check("rst_busy", 32'(bif.busy), 32'd0);

        // Single word 0xA5: req high 6 cycles (3 model + 2 sync + 1), 13 busy cycles in total
        run_xfer(8'hA5, 1'b0, 4'd1, rh, bc);
        check("single_req_hi", 32'(rh), 32'd6);
        check("single_busy_cyc", 32'(bc), 32'd13);

        // Four back-to-back words with src_valid held high
        a0 = accepts;
        foreach (vt[i]) begin
            run_xfer(vt[i].word, vt[i].keep, vt[i].exp_cnt, rh, bc);
            check("b2b_data", 32'(bif.data_out), 32'(vt[i].word));
        end
        repeat (5) tick();
        check("b2b_accepts", 32'(accepts - a0), 32'd4);

        // Stalled receiver
        ack_en = 1'b0;
        wait_ready();
        bif.src_valid = 1'b1; bif.src_data = 8'h5A;
        tick();
        bif.src_valid = 1'b0; bif.src_data = 8'hFF;
        tick();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (bif.req_out !== 1'b1 || bif.src_ready !== 1'b0 ||
                bif.data_out !== 8'h5A || bif.xfer_count !== 4'd5) bad++;
            tick();
        end
        check("stall_hold", 32'(bad), 32'd0);
        ack_en = 1'b1;
        wait_ready();
        check("stall_resume_count", 32'(bif.xfer_count), 32'd6);

        // Reset asserted while in S_REQ
        ack_en = 1'b0;
        bif.src_valid = 1'b1; bif.src_data = 8'h77;
        tick();
        bif.src_valid = 1'b0;
        tick();
        check("pre_rst_req", 32'(bif.req_out), 32'd1);
        #2 rst_b = 1'b0;
        #1;
        check("async_req_drop", 32'(bif.req_out), 32'd0);
        check("async_count_clr", 32'(bif.xfer_count), 32'd0);
        check("async_ready", 32'(bif.src_ready), 32'd1);
        @(negedge clk); rst_b = 1'b1;
        ack_en = 1'b1;
        tick();
        run_xfer(8'h3C, 1'b0, 4'd1, rh, bc);
        check("post_rst_data", 32'(bif.data_out), 32'h3C);

        // Counter wrap with CNT_WIDTH=4
        @(negedge clk); rst_b = 1'b0;
        @(negedge clk); rst_b = 1'b1;
        tick();
        for (int i = 1; i <= 17; i++) begin
            run_xfer(8'(i * 7), 1'b0, 4'(i), rh, bc);
            if (i == 15) check("wrap_15", 32'(bif.xfer_count), 32'd15);
            if (i == 16) check("wrap_16", 32'(bif.xfer_count), 32'd0);
            if (i == 17) check("wrap_17", 32'(bif.xfer_count), 32'd1);
        end

        // ack pulse while idle must not move the FSM
        ack_force = 1'b1; ack_force_en = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bif.src_ready !== 1'b1 || bif.req_out !== 1'b0 || bif.xfer_count !== 4'd1) bad++;
        end
        ack_force = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bif.src_ready !== 1'b1 || bif.req_out !== 1'b0 || bif.xfer_count !== 4'd1) bad++;
        end
        ack_force_en = 1'b0;
        check("idle_ack_ignored", 32'(bad), 32'd0);
        run_xfer(8'hC3, 1'b0, 4'd2, rh, bc);
        check("post_pulse_req_hi", 32'(rh), 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
